// File: rtl/aes_pkg.sv
// Shared AES constants: forward S-box, round constants and key-schedule widths.
package aes_pkg;

  localparam int ROUNDS = 10;
  localparam int KEY_W  = 128;
  localparam int KEYS_W = KEY_W * (ROUNDS + 1);

  localparam logic [7:0] SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[b];
  endfunction

endpackage

// File: rtl/key_expansion_round.sv
// One AES-128 key-schedule step: derives round key r+1 from round key r.
module key_expansion_round
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0] prev,
  input  logic [7:0]       rcon,
  output logic [KEY_W-1:0] next
);

  logic [31:0] t_word;
  logic [31:0] w0, w1, w2, w3;

  // NOTE: blocking assignments here, because each word depends on the one just computed
  // in the same pass; the whole block is one combinational cone with no state.
  always_comb begin
    // SubWord(RotWord(last word of prev)) ^ Rcon
    t_word = {sbox(prev[23:16]), sbox(prev[15:8]), sbox(prev[7:0]), sbox(prev[31:24])}
             ^ {rcon, 24'h0};
    w0 = prev[127:96] ^ t_word;
    w1 = prev[95:64]  ^ w0;
    w2 = prev[63:32]  ^ w1;
    w3 = prev[31:0]   ^ w2;
  end

  assign next = {w0, w1, w2, w3};

endmodule

// File: rtl/key_expansion.sv
// AES-128 key schedule: combinational ten-round expansion with a single output register.
module key_expansion
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [0:KEY_W-1]  key,
  output logic [0:KEYS_W-1] keys
);

  logic [KEY_W-1:0]  round_key [ROUNDS+1];
  logic [0:KEYS_W-1] keys_d;
  logic [0:KEYS_W-1] keys_q;

  // key bit 0 lands in round_key bit 127, so byte 0 stays the most significant byte.
  assign round_key[0] = key;

  for (genvar r = 0; r < ROUNDS; r++) begin : g_round
    key_expansion_round u_round (
      .prev (round_key[r]),
      .rcon (RCON[r+1]),
      .next (round_key[r+1])
    );
  end

  always_comb begin
    keys_d = '0;
    for (int r = 0; r <= ROUNDS; r++) begin
      keys_d[KEY_W*r +: KEY_W] = round_key[r];
    end
  end

  // NOTE: non-blocking assignments for registered state so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) keys_q <= '0;
    else       keys_q <= keys_d;
  end

  assign keys = keys_q;

endmodule

// File: tb/tb_key_expansion.sv
// Self-checking bench for key_expansion: FIPS-197 vectors, corner sequences, random regression.
module tb_key_expansion;

  logic          clk;
  logic          reset;
  logic [0:127]  key;
  logic [0:1407] keys;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference tables derived from GF(2^8) arithmetic, independent of the RTL constants.
  logic [7:0] ref_sbox [256];
  logic [7:0] ref_rcon [1:10];

  typedef struct {
    logic [127:0] key;
    logic [127:0] r1;
    logic [127:0] r10;
  } vec_t;

  vec_t vecs [3];

  key_expansion dut (
    .clk   (clk),
    .reset (reset),
    .key   (key),
    .keys  (keys)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] inv, rc;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rc = 8'h01;
    for (int j = 1; j <= 10; j++) begin
      ref_rcon[j] = rc;
      rc = gf_mul(rc, 8'h02);
    end
  endtask

  // Word-array expansion straight from the w[i] recurrence.
  function automatic logic [0:1407] model_expand(input logic [0:127] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [0:1407] res;
    for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {ref_sbox[t[31:24]], ref_sbox[t[23:16]], ref_sbox[t[15:8]], ref_sbox[t[7:0]]};
        t = t ^ {ref_rcon[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) res[32*i +: 32] = w[i];
    return res;
  endfunction

  function automatic logic [127:0] round_of(input logic [0:1407] b, input int r);
    return b[128*r +: 128];
  endfunction

  task automatic check_round(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_bus(input string name, input logic [0:1407] act, input logic [0:1407] exp);
    int bad;
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      bad = 0;
      for (int r = 10; r >= 0; r--)
        if (round_of(act, r) !== round_of(exp, r)) bad = r;
      $display("FAIL %s: round %0d got %h want %h", name, bad,
               round_of(act, bad), round_of(exp, bad));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [0:127] prev_key;
    logic [0:127] k_a1;

    reset = 1'b0;
    key   = '0;
    build_tables();

    vecs[0] = '{128'h0, 128'h62636363626363636263636362636363,
                128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[2] = '{128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                128'h13111d7fe3944a17f307a78b4d2b30c5};
    k_a1 = vecs[1].key;

    // Asynchronous reset, observed before the first clock edge
    #1 reset = 1'b1;
    key = vecs[1].key;
    #1 check_bus("reset_async", keys, '0);
    repeat (2) step();
    check_bus("reset_hold", keys, '0);

    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      key = vecs[i].key;
      step();
      check_round($sformatf("vec%0d_r0", i),  round_of(keys, 0),  vecs[i].key);
      check_round($sformatf("vec%0d_r1", i),  round_of(keys, 1),  vecs[i].r1);
      check_round($sformatf("vec%0d_r10", i), round_of(keys, 10), vecs[i].r10);
      check_bus($sformatf("vec%0d_full", i), keys, model_expand(vecs[i].key));
    end

    step();
    check_bus("stable_key", keys, model_expand(key));

    // Back-to-back alternation; output must not move until the edge
    prev_key = key;
    for (int j = 0; j < 8; j++) begin
      key = (j % 2 == 0) ? '0 : k_a1;
      #1 check_bus("b2b_before_edge", keys, model_expand(prev_key));
      step();
      check_bus("b2b_after_edge", keys, model_expand(key));
      check_round("b2b_r0", round_of(keys, 0), key);
      prev_key = key;
    end

    // Mid-stream reset between edges
    key = vecs[2].key;
    step();
    check_bus("pre_reset", keys, model_expand(key));
    #2 reset = 1'b1;
    #1 check_bus("mid_reset_async", keys, '0);
    step();
    check_bus("mid_reset_hold", keys, '0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check_bus("after_reset", keys, model_expand(key));

    for (int j = 0; j < 1000; j++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
      check_bus("random", keys, model_expand(key));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
